regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 5, register address width; DEPTH = 2**ADDR_SIZE.
REQ-002 SHALL have parameter WORD_SIZE, default 64, register data width.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..8).
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 RegWrite  input  1  write enable.
REQ-008 wr_add  input  ADDR_SIZE  write address.
REQ-009 wr_data  input  WORD_SIZE  write data.
REQ-010 rd_addr  input  NUM_RD*ADDR_SIZE  packed read addresses; port i at bits [i*ADDR_SIZE +: ADDR_SIZE].
REQ-011 rd_data  output  NUM_RD*WORD_SIZE  packed registered read data; port i at bits [i*WORD_SIZE +: WORD_SIZE].
REQ-012 init_busy  output  1  high while the zero-initialisation sweep runs.

Function
REQ-013 SHALL implement a two-state FSM: INIT and RUN.
REQ-014 In INIT, SHALL write zero to entry init_cnt each cycle and increment init_cnt (ADDR_SIZE bits).
REQ-015 SHALL go INIT->RUN on the edge where init_cnt == DEPTH-1; INIT lasts exactly DEPTH cycles.
REQ-016 init_busy SHALL be 1 in INIT and 0 in RUN.
REQ-017 In INIT, RegWrite SHALL be ignored and all rd_data ports SHALL register zero.
REQ-018 In RUN, RegWrite=1 SHALL write wr_data to entry wr_add at the rising edge.
REQ-019 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0.
REQ-020 In RUN, each port i SHALL register mem[rd_addr_i] at the rising edge; rd_data is valid one cycle after the address is presented.
REQ-021 Any number of read ports SHALL read the same address in the same cycle without conflict.
REQ-022 A read of an address not written since INIT SHALL return 0.

Reset
REQ-023 rst=0 SHALL immediately force state=INIT, init_cnt=0, rd_data=0, init_busy=1, independent of clk.
REQ-024 Reset asserted mid-operation SHALL restart the full INIT sweep after release; prior contents SHALL read as 0 afterwards.
REQ-025 Storage array SHALL NOT need async reset; zeroing is done by the INIT sweep.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN defined: in RUN, when RegWrite=1 and wr_add == rd_addr_i (and not the zero register when ZERO_REG=1), port i SHALL register wr_data in that cycle (write-through).
REQ-027 REGFILE_BYPASS_EN undefined: port i SHALL register the pre-write value; the new value is visible from the next read.

Structure
REQ-028 Shared package regfile_pkg SHALL hold FSM state encoding (INIT=1'b0, RUN=1'b1) and default ADDR_SIZE/WORD_SIZE constants.
REQ-029 One sub-module, regfile_rd_port, SHALL implement a single registered read port including the bypass mux, instantiated NUM_RD times by generate.

Verification
REQ-030 Release rst at t=9 -> init_busy=1 for 32 rising edges, then 0; both rd_data = 0 throughout.
REQ-031 RUN: RegWrite=1, wr_add=1, wr_data=464; next cycle rd_addr port0=1 -> port0 reads 464 one edge later; port1 on addr 2 reads 0.
REQ-032 ZERO_REG=1: write 5 to address 0, read address 0 on both ports -> both 0.
REQ-033 Same cycle write addr 2 = 0xABCD, port1 reads addr 2 (old 0) -> port1 = 0xABCD with REGFILE_BYPASS_EN, 0 without; both 0xABCD next cycle.
REQ-034 Write addr 1 = 464, assert rst mid-cycle -> rd_data=0 immediately; after release and 32-cycle INIT, addr 1 reads 0.
REQ-035 During INIT, RegWrite=1, wr_add=3, wr_data=7 -> after INIT, addr 3 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared definitions for the multi-port register file.
//   state_e        : controller states (INIT sweeps zeros, RUN is normal use)
//   DEF_ADDR_SIZE  : default register address width
//   DEF_WORD_SIZE  : default register data width
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_ADDR_SIZE = 5;
  localparam int DEF_WORD_SIZE = 64;

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port -- one registered read port of regfile_mp.
// Optional feature: define REGFILE_BYPASS_EN to make a same-cycle write to
// the addressed register appear on this port (write-through); otherwise the
// port returns the pre-write contents.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset, clears the output register
//   run        : register file is in RUN (outputs zero while initialising)
//   rd_addr    : read address for this port
//   mem_rdata  : storage contents at rd_addr
//   wr_en      : effective write this cycle (already excludes register 0)
//   wr_add     : write address
//   wr_data    : write data
//   rd_data    : registered read data
module regfile_rd_port #(
  parameter int ADDR_SIZE = 5,
  parameter int WORD_SIZE = 64,
  parameter int ZERO_REG  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_add,
  input  logic [WORD_SIZE-1:0] wr_data,
  output logic [WORD_SIZE-1:0] rd_data
);

  logic [WORD_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 byp_hit;

`ifdef REGFILE_BYPASS_EN
  assign byp_hit = wr_en && (wr_add == rd_addr);
`else
  assign byp_hit = 1'b0;
  // Write-address side is only needed for write-through.
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_add};
`endif

  always_comb begin
    rd_data_d = '0;
    if (run) begin
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
        rd_data_d = '0;
      end else if (byp_hit) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp -- register file with one write port and NUM_RD registered
// read ports. After reset an INIT sweep writes zero to every entry (one per
// cycle, DEPTH cycles), so the storage array itself carries no reset.
// Optional feature: REGFILE_BYPASS_EN enables write-through on read ports.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   RegWrite   : write enable (ignored during INIT)
//   wr_add     : write address
//   wr_data    : write data
//   rd_addr    : packed read addresses, port i at [i*ADDR_SIZE +: ADDR_SIZE]
//   rd_data    : packed registered read data, port i at [i*WORD_SIZE +: WORD_SIZE]
//   init_busy  : high while the zeroing sweep runs
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           RegWrite,
  input  logic [ADDR_SIZE-1:0]           wr_add,
  input  logic [WORD_SIZE-1:0]           wr_data,
  input  logic [NUM_RD*ADDR_SIZE-1:0]    rd_addr,
  output logic [NUM_RD*WORD_SIZE-1:0]    rd_data,
  output logic                           init_busy
);

  localparam int                   DEPTH     = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   init_cnt_q, init_cnt_d;
  logic                   run;
  logic                   run_wr;
  logic                   mem_we;
  logic [ADDR_SIZE-1:0]   mem_waddr;
  logic [WORD_SIZE-1:0]   mem_wdata;
  logic [WORD_SIZE-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    run_wr     = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = init_cnt_q;
    mem_wdata  = '0;
    case (state_q)
      INIT: begin
        mem_we     = 1'b1;
        init_cnt_d = init_cnt_q + ADDR_SIZE'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Writes to register 0 are dropped so it stays zero from the sweep.
        run_wr    = RegWrite && !((ZERO_REG != 0) && (wr_add == '0));
        mem_we    = run_wr;
        mem_waddr = wr_add;
        mem_wdata = wr_data;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign run       = (state_q == RUN);
  assign init_busy = (state_q == INIT);

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .ADDR_SIZE (ADDR_SIZE),
      .WORD_SIZE (WORD_SIZE),
      .ZERO_REG  (ZERO_REG)
    ) u_rd_port (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .rd_addr   (rd_addr[i*ADDR_SIZE +: ADDR_SIZE]),
      .mem_rdata (mem_q[rd_addr[i*ADDR_SIZE +: ADDR_SIZE]]),
      .wr_en     (run_wr),
      .wr_add    (wr_add),
      .wr_data   (wr_data),
      .rd_data   (rd_data[i*WORD_SIZE +: WORD_SIZE])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- directed testbench for regfile_mp (default parameters).
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int WW = 64;
  localparam int NR = 2;

  logic             clk;
  logic             rst;
  logic             RegWrite;
  logic [AW-1:0]    wr_add;
  logic [WW-1:0]    wr_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*WW-1:0] rd_data;
  logic             init_busy;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp #(
    .ADDR_SIZE (AW),
    .WORD_SIZE (WW),
    .NUM_RD    (NR),
    .ZERO_REG  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RegWrite  (RegWrite),
    .wr_add    (wr_add),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] port(input int i);
    return rd_data[i*WW +: WW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Runs the 32-edge INIT sweep, checking busy and both outputs each edge.
  task automatic sweep(input string tag);
    for (int i = 1; i <= 32; i++) begin
      step();
      chk({tag, "_busy"}, {63'd0, init_busy}, (i < 32) ? 64'd1 : 64'd0);
      chk({tag, "_p0"}, port(0), 64'd0);
      chk({tag, "_p1"}, port(1), 64'd0);
    end
  endtask

  initial begin
    rst      = 1'b0;
    RegWrite = 1'b0;
    wr_add   = '0;
    wr_data  = '0;
    rd_addr  = '0;

    // Reset state
    #2;
    chk("rst_busy", {63'd0, init_busy}, 64'd1);
    chk("rst_p0", port(0), 64'd0);
    chk("rst_p1", port(1), 64'd0);

    // Write attempt during INIT must be ignored
    RegWrite = 1'b1;
    wr_add   = 5'd3;
    wr_data  = 64'd7;
    set_rd(5'd3, 5'd1);
    #7;
    rst = 1'b1;
    sweep("init1");

    // Address 3 still zero after INIT-time write attempt
    RegWrite = 1'b0;
    set_rd(5'd3, 5'd3);
    step();
    chk("init_wr_ign_p0", port(0), 64'd0);
    chk("init_wr_ign_p1", port(1), 64'd0);

    // Basic write then read, other port on an unwritten address
    RegWrite = 1'b1;
    wr_add   = 5'd1;
    wr_data  = 64'd464;
    step();
    RegWrite = 1'b0;
    set_rd(5'd1, 5'd2);
    step();
    chk("wr1_p0", port(0), 64'd464);
    chk("unwr2_p1", port(1), 64'd0);

    // Register 0 is hardwired to zero
    RegWrite = 1'b1;
    wr_add   = 5'd0;
    wr_data  = 64'd5;
    set_rd(5'd0, 5'd0);
    step();
    chk("z0_same_p0", port(0), 64'd0);
    chk("z0_same_p1", port(1), 64'd0);
    RegWrite = 1'b0;
    step();
    chk("z0_next_p0", port(0), 64'd0);
    chk("z0_next_p1", port(1), 64'd0);

    // Same-cycle write/read of address 2
    RegWrite = 1'b1;
    wr_add   = 5'd2;
    wr_data  = 64'hABCD;
    set_rd(5'd1, 5'd2);
    step();
    chk("raw_p0", port(0), 64'd464);
`ifdef REGFILE_BYPASS_EN
    chk("raw_p1", port(1), 64'hABCD);
`else
    chk("raw_p1", port(1), 64'd0);
`endif
    RegWrite = 1'b0;
    set_rd(5'd2, 5'd2);
    step();
    chk("raw_next_p0", port(0), 64'hABCD);
    chk("raw_next_p1", port(1), 64'hABCD);

    // Top address, all-ones data, both ports on it
    RegWrite = 1'b1;
    wr_add   = 5'd31;
    wr_data  = '1;
    step();
    RegWrite = 1'b0;
    set_rd(5'd31, 5'd31);
    step();
    chk("top_p0", port(0), {WW{1'b1}});
    chk("top_p1", port(1), {WW{1'b1}});

    // RegWrite low must not write
    wr_add  = 5'd5;
    wr_data = 64'h1234;
    set_rd(5'd5, 5'd2);
    step();
    step();
    chk("nowr_p0", port(0), 64'd0);
    chk("nowr_p1", port(1), 64'hABCD);

    // Overwrite address 1
    RegWrite = 1'b1;
    wr_add   = 5'd1;
    wr_data  = 64'h5555_AAAA_0000_FFFF;
    step();
    RegWrite = 1'b0;
    set_rd(5'd31, 5'd1);
    step();
    chk("ovr_p0", port(0), {WW{1'b1}});
    chk("ovr_p1", port(1), 64'h5555_AAAA_0000_FFFF);

    // Mid-operation reset
    RegWrite = 1'b1;
    wr_add   = 5'd1;
    wr_data  = 64'd464;
    step();
    RegWrite = 1'b0;
    set_rd(5'd1, 5'd31);
    step();
    chk("pre_rst_p0", port(0), 64'd464);
    #2;
    rst = 1'b0;
    #1;
    chk("async_busy", {63'd0, init_busy}, 64'd1);
    chk("async_p0", port(0), 64'd0);
    chk("async_p1", port(1), 64'd0);
    #3;
    rst = 1'b1;
    sweep("init2");
    step();
    chk("post_rst_p0", port(0), 64'd0);
    chk("post_rst_p1", port(1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
